// File: rtl/acc_reg.sv
// acc_reg: 9-bit accumulator register with load, add-result load and
// logical right shift commands (priority load > ad > sh).
//
// Ports:
//   clk     in   1  sole clock, rising edge
//   rst     in   1  asynchronous active-high reset, clears the register
//   entrada in   9  data source for load (low nibble) and ad (upper field)
//   load    in   1  ACC <= {5'b0, entrada[3:0]}
//   sh      in   1  ACC <= {1'b0, ACC[8:1]}
//   ad      in   1  ACC[8:4] <= entrada[8:4], ACC[3:0] kept
//   saida   out  9  register contents, driven straight from the flops
module acc_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] entrada,
    input  logic       load,
    input  logic       sh,
    input  logic       ad,
    output logic [8:0] saida
);

    logic [8:0] acc_q;
    logic [8:0] acc_d;

    // Commands are not mutually exclusive, so the if-chain encodes priority.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = {5'b00000, entrada[3:0]};
        end else if (ad) begin
            acc_d = {entrada[8:4], acc_q[3:0]};
        end else if (sh) begin
            // Zero fill: repeated shifts settle at zero, never rotate.
            acc_d = {1'b0, acc_q[8:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 9'b000000000;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign saida = acc_q;

endmodule

// File: tb/tb_acc_reg.sv
// tb_acc_reg: table-driven vectors plus scoreboard for acc_reg,
// with hand-written asynchronous reset sequences and a random model run.
module tb_acc_reg;

    logic       clk;
    logic       rst;
    logic [8:0] entrada;
    logic       load;
    logic       sh;
    logic       ad;
    logic [8:0] saida;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];

    typedef struct {
        logic       ld;
        logic       a;
        logic       s;
        logic [8:0] ent;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[21];

    acc_reg dut (
        .clk     (clk),
        .rst     (rst),
        .entrada (entrada),
        .load    (load),
        .sh      (sh),
        .ad      (ad),
        .saida   (saida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [8:0] act,
                         input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one command on the falling edge, push its expected result,
    // then pop and compare just after the capturing rising edge.
    task automatic step(input logic l, input logic a, input logic s,
                        input logic [8:0] e, input logic [8:0] exp,
                        input string nm);
        logic [8:0] want;
        @(negedge clk);
        load    = l;
        ad      = a;
        sh      = s;
        entrada = e;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            want = sb_q.pop_front();
            check(nm, saida, want);
        end
    endtask

    function automatic logic [8:0] model(input logic [8:0] acc,
                                         input logic l, input logic a,
                                         input logic s,
                                         input logic [8:0] e);
        logic [8:0] r;
        r = acc;
        if (l)
            r = {5'd0, e[3:0]};
        else if (a) begin
            r[8:4] = e[8:4];
        end else if (s)
            r = acc >> 1;
        return r;
    endfunction

    initial begin
        logic [8:0] m;
        logic [8:0] e;
        logic       l;
        logic       a;
        logic       s;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 9'b101011101, 9'b000001101};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 9'b101011101, 9'b101011101};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b010101110};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 9'b111111111, 9'b001010111};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000101011};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000010101};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000001010};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000101};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000010};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000001};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000000};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 9'b000000000, 9'b000000000};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 9'b111110110, 9'b000000110};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 9'b101011101, 9'b000001101};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 9'b101011101, 9'b101011101};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 9'b010100000, 9'b010101101};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 9'b111111111, 9'b010101101};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 9'b000000000, 9'b010101101};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 9'b100010001, 9'b010101101};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 9'b110011111, 9'b110011101};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 9'b000001111, 9'b000001111};

        rst     = 1'b1;
        load    = 1'b1;
        ad      = 1'b1;
        sh      = 1'b1;
        entrada = 9'b111111111;
        #1;
        check("reset_immediate", saida, 9'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ignores_cmds", saida, 9'd0);
        @(negedge clk);
        load = 1'b0;
        ad   = 1'b0;
        sh   = 1'b0;
        rst  = 1'b0;

        step(1'b0, 1'b0, 1'b0, 9'b111111111, 9'd0, "post_reset_idle");

        for (int i = 0; i < 21; i++)
            step(vecs[i].ld, vecs[i].a, vecs[i].s, vecs[i].ent,
                 vecs[i].exp, $sformatf("vec%0d", i));

        // Reset pulsed between edges while ACC is non-zero.
        step(1'b1, 1'b0, 1'b0, 9'b000001011, 9'b000001011, "pre_rst_load");
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", saida, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        #1;
        check("release_zero", saida, 9'd0);
        step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, "release_hold");
        step(1'b1, 1'b1, 1'b0, 9'b011100111, 9'b000000111, "load_after_rst");

        // Reset during a shift run, held across an edge with commands set.
        step(1'b0, 1'b1, 1'b0, 9'b111110000, 9'b111110111, "run_ad");
        step(1'b0, 1'b0, 1'b1, 9'd0, 9'b011111011, "run_sh1");
        step(1'b0, 1'b0, 1'b1, 9'd0, 9'b001111101, "run_sh2");
        #2;
        rst = 1'b1;
        #1;
        check("run_async_clear", saida, 9'd0);
        @(posedge clk);
        #1;
        check("run_rst_held", saida, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 9'd0, 9'd0, "run_resume_sh");
        step(1'b0, 1'b1, 1'b0, 9'b101000000, 9'b101000000, "run_resume_ad");

        // Random commands against an independent model.
        m = 9'b101000000;
        for (int i = 0; i < 60; i++) begin
            l = ($urandom_range(0, 4) == 0);
            a = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 1) == 0);
            e = 9'($urandom_range(0, 511));
            m = model(m, l, a, s, e);
            step(l, a, s, e, m, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
